// File: rtl/slc3_mem_pkg.sv
// Shared types and defaults for the SLC-3 memory responder.
package slc3_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        P1,
        P2,
        HOLD
    } state_t;

    localparam int          DEF_ADDR_W  = 10;
    localparam logic [15:0] DEF_IO_ADDR = 16'hFFFF;

endpackage

// File: rtl/slc3_bram_2r.sv
// Single-port block RAM: registered address plus an output register (two-stage read).
// A write at the address edge is seen by the read that follows it.
module slc3_bram_2r #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       din,
    output logic [15:0]       dout
);

    logic [15:0]       r_mem [2**ADDR_W];
    logic [ADDR_W-1:0] r_addr;

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= din;
        end
        r_addr <= addr;
        dout   <= r_mem[r_addr];
    end

endmodule

// File: rtl/slc3_mem_responder.sv
// Answers SLC-3 memory strobes with the fixed 3-cycle wait-state protocol:
// on-chip RAM plus one memory-mapped I/O word (switches in, hex display out).
module slc3_mem_responder
    import slc3_mem_pkg::*;
#(
    parameter int          ADDR_W  = DEF_ADDR_W,
    parameter logic [15:0] IO_ADDR = DEF_IO_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_mem_ena,
    input  logic        mem_wr_ena,
    input  logic [15:0] addr,
    input  logic [15:0] mem_wdata,
    output logic [15:0] mem_rdata,
    output logic        rdata_valid,
    input  logic [15:0] sw_i,
    output logic [15:0] hex_o
);

    state_t      r_state;
    state_t      w_state_next;
    logic        w_e0;
    logic        w_is_io;
    logic        w_ram_we;
    logic [15:0] w_ram_dout;
    logic [15:0] w_p2_data;
    logic        r_io_sel1;
    logic        r_io_sel2;
    logic [15:0] r_io_d1;
    logic [15:0] r_io_d2;
    logic [15:0] r_hold;
    logic [15:0] r_hex;

    // Reset in the same cycle as the strobe suppresses E0 entirely.
    assign w_e0     = (r_state == IDLE) && mem_mem_ena && !reset;
    assign w_is_io  = (addr == IO_ADDR);
    assign w_ram_we = w_e0 && mem_wr_ena && !w_is_io;

    slc3_bram_2r #(
        .ADDR_W(ADDR_W)
    ) u_bram (
        .clk (clk),
        .we  (w_ram_we),
        .addr(addr[ADDR_W-1:0]),
        .din (mem_wdata),
        .dout(w_ram_dout)
    );

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (mem_mem_ena) w_state_next = P1;
            P1:      w_state_next = mem_mem_ena ? P2 : IDLE;
            P2:      w_state_next = mem_mem_ena ? HOLD : IDLE;
            HOLD:    if (!mem_mem_ena) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // I/O path mirrors the RAM's two stages so both sources arrive in P2.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_io_sel1 <= 1'b0;
            r_io_sel2 <= 1'b0;
            r_io_d1   <= 16'h0000;
            r_io_d2   <= 16'h0000;
            r_hold    <= 16'h0000;
            r_hex     <= 16'h0000;
        end else begin
            r_state <= w_state_next;
            if (w_e0) begin
                r_io_sel1 <= w_is_io;
                r_io_d1   <= mem_wr_ena ? mem_wdata : sw_i;
                if (w_is_io && mem_wr_ena) begin
                    r_hex <= mem_wdata;
                end
            end
            if (r_state == P1) begin
                r_io_sel2 <= r_io_sel1;
                r_io_d2   <= r_io_d1;
            end
            if (r_state == P2) begin
                r_hold <= w_p2_data;
            end
        end
    end

    // Live data in P2; the captured copy keeps the output frozen afterwards.
    assign w_p2_data   = r_io_sel2 ? r_io_d2 : w_ram_dout;
    assign mem_rdata   = (r_state == P2) ? w_p2_data : r_hold;
    assign rdata_valid = (r_state == P2) || (r_state == HOLD);
    assign hex_o       = r_hex;

endmodule

// File: tb/tb_slc3_mem_responder.sv
// Randomized and directed checking of slc3_mem_responder against an access-level model.
module tb_slc3_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_mem_ena;
    logic        mem_wr_ena;
    logic [15:0] addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        rdata_valid;
    logic [15:0] sw_i;
    logic [15:0] hex_o;

    int n_checks = 0;
    int n_errors = 0;

    // Model: position within the current access (0 = idle, 1 = E0 done, ...)
    int          m_pos;
    logic [15:0] m_res;
    logic [15:0] m_last;
    logic [15:0] m_hex;
    bit          m_res_known;
    bit          m_last_known;
    logic [15:0] m_mem   [1024];
    bit          m_known [1024];

    always #5 clk = ~clk;

    slc3_mem_responder dut (
        .clk        (clk),
        .reset      (reset),
        .mem_mem_ena(mem_mem_ena),
        .mem_wr_ena (mem_wr_ena),
        .addr       (addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .rdata_valid(rdata_valid),
        .sw_i       (sw_i),
        .hex_o      (hex_o)
    );

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle, advance the model across the edge, then compare outputs.
    task automatic step(input bit stb, input bit wr, input logic [15:0] a,
                        input logic [15:0] wd, input logic [15:0] sw, input bit rst);
        logic [9:0]  idx;
        bit          io;
        logic [15:0] exp_rd;
        bit          exp_known;
        @(negedge clk);
        reset       = rst;
        mem_mem_ena = stb;
        mem_wr_ena  = wr;
        addr        = a;
        mem_wdata   = wd;
        sw_i        = sw;
        @(posedge clk);
        #1;
        if (rst) begin
            m_pos = 0; m_last = 16'h0000; m_last_known = 1'b1; m_hex = 16'h0000;
        end else begin
            case (m_pos)
                0: if (stb) begin
                    io  = (a == 16'hFFFF);
                    idx = a[9:0];
                    if (wr && io) m_hex = wd;
                    if (wr && !io) begin
                        m_mem[idx] = wd; m_known[idx] = 1'b1;
                    end
                    if (io) begin
                        m_res = wr ? wd : sw; m_res_known = 1'b1;
                    end else begin
                        m_res = m_mem[idx]; m_res_known = m_known[idx];
                    end
                    m_pos = 1;
                end
                1: m_pos = stb ? 2 : 0;
                2: begin
                    m_last = m_res; m_last_known = m_res_known;
                    m_pos  = stb ? 3 : 0;
                end
                default: if (!stb) m_pos = 0;
            endcase
        end
        exp_rd    = (m_pos == 2) ? m_res : m_last;
        exp_known = (m_pos == 2) ? m_res_known : m_last_known;
        check_eq("valid", {15'd0, rdata_valid}, (m_pos >= 2) ? 16'd1 : 16'd0);
        if (exp_known) check_eq("rdata", mem_rdata, exp_rd);
        check_eq("hex", hex_o, m_hex);
    endtask

    task automatic gap();
        step(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    endtask

    task automatic wr3(input logic [15:0] a, input logic [15:0] wd);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, a, wd, 16'h0000, 1'b0);
        gap();
        $display("write %h <= %h", a, wd);
    endtask

    // 3-cycle read: invalid in the second strobe cycle, valid with data in the third.
    task automatic rd3(input logic [15:0] a, input logic [15:0] sw, input logic [15:0] exp, input string tag);
        step(1'b1, 1'b0, a, 16'h0000, sw, 1'b0);
        check_eq({tag, "_p1_valid"}, {15'd0, rdata_valid}, 16'd0);
        step(1'b1, 1'b0, a, 16'h0000, sw, 1'b0);
        check_eq({tag, "_p2_valid"}, {15'd0, rdata_valid}, 16'd1);
        check_eq(tag, mem_rdata, exp);
        step(1'b1, 1'b0, a, 16'h0000, sw, 1'b0);
        gap();
        $display("read  %h -> %h", a, mem_rdata);
    endtask

    initial begin
        logic [15:0] ra;
        int          len;
        bit          rwr;
        m_pos = 0; m_res = 16'h0000; m_last = 16'h0000; m_hex = 16'h0000;
        m_res_known = 1'b1; m_last_known = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            m_mem[i] = 16'h0000; m_known[i] = 1'b0;
        end

        step(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1);
        step(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1);
        check_eq("rst_rdata", mem_rdata, 16'h0000);
        check_eq("rst_valid", {15'd0, rdata_valid}, 16'd0);
        check_eq("rst_hex", hex_o, 16'h0000);
        gap();

        wr3(16'h0005, 16'h1234);
        rd3(16'h0005, 16'h0000, 16'h1234, "ram_rd");

        wr3(16'h03FF, 16'h7777);
        step(1'b1, 1'b1, 16'hFFFF, 16'hBEEF, 16'h0000, 1'b0);
        check_eq("hex_e0p1", hex_o, 16'hBEEF);
        step(1'b1, 1'b1, 16'hFFFF, 16'hBEEF, 16'h0000, 1'b0);
        step(1'b1, 1'b1, 16'hFFFF, 16'hBEEF, 16'h0000, 1'b0);
        gap();
        rd3(16'h03FF, 16'h0000, 16'h7777, "io_no_ram");
        rd3(16'hFFFF, 16'h00A5, 16'h00A5, "io_rd");

        for (int k = 1; k <= 6; k++) begin
            step(1'b1, 1'b1, 16'h0010, 16'(k), 16'h0000, 1'b0);
            if (k == 2) check_eq("commit_p2", mem_rdata, 16'h0001);
            if (k >= 2 && k <= 5) check_eq("commit_valid", {15'd0, rdata_valid}, 16'd1);
        end
        gap();
        rd3(16'h0010, 16'h0000, 16'h0001, "commit_rd");

        wr3(16'h0402, 16'h5555);
        rd3(16'h0002, 16'h0000, 16'h5555, "alias_rd");

        step(1'b1, 1'b1, 16'h0020, 16'hAAAA, 16'h0000, 1'b0);
        gap();
        rd3(16'h0020, 16'h0000, 16'hAAAA, "abort_rd");

        step(1'b1, 1'b0, 16'h0020, 16'h0000, 16'h0000, 1'b0);
        step(1'b1, 1'b0, 16'h0020, 16'h0000, 16'h0000, 1'b1);
        check_eq("rstp1_rdata", mem_rdata, 16'h0000);
        check_eq("rstp1_valid", {15'd0, rdata_valid}, 16'd0);
        check_eq("rstp1_hex", hex_o, 16'h0000);
        gap();
        $display("reset during P1 of read at 0020");

        wr3(16'h0030, 16'h3030);
        wr3(16'h0031, 16'h3131);
        rd3(16'h0030, 16'h0000, 16'h3030, "cpu_fetch");
        rd3(16'h0031, 16'h0000, 16'h3131, "cpu_load");
        wr3(16'h0032, 16'h3232);
        rd3(16'h0030, 16'h0000, 16'h3030, "cpu_nospur0");
        rd3(16'h0031, 16'h0000, 16'h3131, "cpu_nospur1");
        rd3(16'h0032, 16'h0000, 16'h3232, "cpu_store");

        for (int t = 0; t < 200; t++) begin
            len = $urandom_range(1, 6);
            rwr = 1'($urandom);
            ra  = 16'($urandom);
            if ($urandom_range(0, 3) == 0) ra = 16'hFFFF;
            else ra = ra & 16'hFC0F;
            for (int i = 0; i < len; i++) begin
                step(1'b1, (i == 0) ? rwr : 1'($urandom), ra, 16'($urandom),
                     16'($urandom), ($urandom_range(0, 49) == 0));
            end
            for (int g = 0; g < $urandom_range(1, 2); g++) begin
                step(1'b0, 1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'b0);
            end
            $display("rand %0d: %s addr=%h len=%0d rdata=%h hex=%h",
                     t, rwr ? "wr" : "rd", ra, len, mem_rdata, hex_o);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
